// File: rtl/hazard_control_unit_pkg.sv
// hazard_control_unit_pkg: shared types, constants and helpers for the hazard controller
//   mdu_state_t : MDU tracker state (IDLE=0, BUSY=1)
//   ZERO_REG    : hard-wired zero register number
//   reg_hit     : 1 when an ID source register is used, is not $0 and equals a destination
package hazard_control_unit_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    localparam logic [4:0] ZERO_REG = 5'd0;

    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src, input logic uses);
        return uses && (src != ZERO_REG) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: pipeline-side bundle of the hazard controller
//   master : the pipeline, drives ID/EX/MEM decode fields and imem_ready, receives strobes
//   slave  : the hazard controller, receives decode fields, drives strobes, mdu_busy, counters
interface hazard_control_unit_if #(parameter int CNT_W = 16);

    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_uses_rs;
    logic             ID_uses_rt;
    logic             ID_is_branch;
    logic             ID_branch_taken;
    logic             ID_jump;
    logic             ID_reads_hilo;
    logic             ID_mdu_op;
    logic             EX_MemRead;
    logic             EX_RegWrite;
    logic [4:0]       EX_WriteReg;
    logic             MEM_MemRead;
    logic [4:0]       MEM_WriteReg;
    logic             imem_ready;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Bubble;
    logic             mdu_busy;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_is_branch, ID_branch_taken, ID_jump,
               ID_reads_hilo, ID_mdu_op, EX_MemRead, EX_RegWrite, EX_WriteReg, MEM_MemRead,
               MEM_WriteReg, imem_ready,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, mdu_busy, stall_count, flush_count
    );

    modport slave (
        input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_is_branch, ID_branch_taken, ID_jump,
               ID_reads_hilo, ID_mdu_op, EX_MemRead, EX_RegWrite, EX_WriteReg, MEM_MemRead,
               MEM_WriteReg, imem_ready,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, mdu_busy, stall_count, flush_count
    );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones
//   clk, reset (sync, active-low), inc : count one event at this edge, count : current value
module sat_counter #(parameter int W = 16) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk)
        if (!reset)
            count <= '0;
        else if (inc && count != '1)
            count <= count + W'(1);

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use / branch / MDU / fetch stall and redirect-flush control
//   clk, reset (sync, active-low)
//   hz : decode fields in, PCWrite/IF_ID_Write/IF_ID_Flush/ID_EX_Bubble, mdu_busy and
//        saturating stall_count/flush_count out
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    hazard_control_unit_if.slave  hz
);

    logic       hit_ex, hit_mem, load_use, br_dep, mdu_hold, stall, redirect, issue;
    mdu_state_t state;
    logic [3:0] cnt;

    always_comb begin
        hit_ex   = reg_hit(hz.EX_WriteReg, hz.ID_rs, hz.ID_uses_rs) ||
                   reg_hit(hz.EX_WriteReg, hz.ID_rt, hz.ID_uses_rt);
        hit_mem  = reg_hit(hz.MEM_WriteReg, hz.ID_rs, hz.ID_uses_rs) ||
                   reg_hit(hz.MEM_WriteReg, hz.ID_rt, hz.ID_uses_rt);
        load_use = hz.EX_MemRead && hit_ex;
        br_dep   = hz.ID_is_branch && ((hz.EX_RegWrite && hit_ex) || (hz.MEM_MemRead && hit_mem));
        // HI/LO are readable in the last BUSY cycle (count 0), so only earlier cycles hold
        mdu_hold = state == BUSY && cnt != 4'd0 && (hz.ID_reads_hilo || hz.ID_mdu_op);
        stall    = reset && (load_use || br_dep || mdu_hold || !hz.imem_ready);
        redirect = reset && !stall && (hz.ID_jump || (hz.ID_is_branch && hz.ID_branch_taken));
        issue    = hz.ID_mdu_op && !stall;
    end

    assign hz.PCWrite      = !stall;
    assign hz.IF_ID_Write  = !stall;
    assign hz.ID_EX_Bubble = stall;
    assign hz.IF_ID_Flush  = redirect;
    assign hz.mdu_busy     = reset && state == BUSY;

    // A queued mdu op can only issue while IDLE or in the final BUSY cycle, where it
    // immediately restarts the latency window.
    always_ff @(posedge clk)
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else if (issue) begin
            state <= BUSY;
            cnt   <= 4'(MDU_LATENCY - 1);
        end else if (state == BUSY) begin
            state <= (cnt == 4'd0) ? IDLE : BUSY;
            cnt   <= (cnt == 4'd0) ? cnt : cnt - 4'd1;
        end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!hz.PCWrite),
        .count (hz.stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hz.IF_ID_Flush),
        .count (hz.flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: scoreboard bench with directed and randomized hazard traffic
module tb_hazard_control_unit;

    localparam int LAT = 4;
    localparam int W   = 16;
    localparam int SAT = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.CNT_W(W)) hz();

    hazard_control_unit #(.MDU_LATENCY(LAT), .CNT_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    typedef struct packed {
        logic [4:0] rs, rt;
        logic       urs, urt, br, tk, j, hilo, mop, exmr, exrw;
        logic [4:0] exw;
        logic       memr;
        logic [4:0] memw;
        logic       ready, rst_n;
    } stim_t;

    typedef struct packed {
        logic [4:0]   ctl;
        logic [W-1:0] sc, fc;
        logic         chk_cnt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   rem = 0;
    int   m_sc = 0;
    int   m_fc = 0;
    bit   cnt_known = 0;

    function automatic bit hit(input logic [4:0] dst, input logic [4:0] src, input logic uses);
        return uses && src != 0 && src == dst;
    endfunction

    function automatic stim_t nop();
        stim_t s = '0;
        s.ready = 1'b1;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rs    = 5'($urandom_range(0, 3));
        s.rt    = 5'($urandom_range(0, 3));
        s.urs   = $urandom_range(0, 3) != 0;
        s.urt   = $urandom_range(0, 1) != 0;
        s.br    = $urandom_range(0, 4) == 0;
        s.tk    = $urandom_range(0, 1) != 0;
        s.j     = $urandom_range(0, 9) == 0;
        s.hilo  = $urandom_range(0, 6) == 0;
        s.mop   = $urandom_range(0, 8) == 0;
        s.exmr  = $urandom_range(0, 3) == 0;
        s.exrw  = $urandom_range(0, 1) != 0;
        s.exw   = 5'($urandom_range(0, 3));
        s.memr  = $urandom_range(0, 3) == 0;
        s.memw  = 5'($urandom_range(0, 3));
        s.ready = $urandom_range(0, 9) != 0;
        s.rst_n = $urandom_range(0, 299) != 0;
        return s;
    endfunction

    // Reference: rem = cycles until the MDU result exists (0 = no op in flight).
    task automatic step(input stim_t s);
        exp_t e;
        bit   ex, mem, st, fl;
        @(posedge clk);
        #1;
        reset              = s.rst_n;
        hz.ID_rs           = s.rs;
        hz.ID_rt           = s.rt;
        hz.ID_uses_rs      = s.urs;
        hz.ID_uses_rt      = s.urt;
        hz.ID_is_branch    = s.br;
        hz.ID_branch_taken = s.tk;
        hz.ID_jump         = s.j;
        hz.ID_reads_hilo   = s.hilo;
        hz.ID_mdu_op       = s.mop;
        hz.EX_MemRead      = s.exmr;
        hz.EX_RegWrite     = s.exrw;
        hz.EX_WriteReg     = s.exw;
        hz.MEM_MemRead     = s.memr;
        hz.MEM_WriteReg    = s.memw;
        hz.imem_ready      = s.ready;
        e.sc      = W'(m_sc);
        e.fc      = W'(m_fc);
        e.chk_cnt = cnt_known;
        if (!s.rst_n) begin
            e.ctl     = 5'b11000;
            m_sc      = 0;
            m_fc      = 0;
            rem       = 0;
            cnt_known = 1;
        end else begin
            ex  = hit(s.exw, s.rs, s.urs) || hit(s.exw, s.rt, s.urt);
            mem = hit(s.memw, s.rs, s.urs) || hit(s.memw, s.rt, s.urt);
            st  = (s.exmr && ex) || (s.br && ((s.exrw && ex) || (s.memr && mem))) ||
                  (rem > 1 && (s.hilo || s.mop)) || !s.ready;
            fl  = !st && (s.j || (s.br && s.tk));
            e.ctl = {!st, !st, fl, st, rem > 0};
            if (st && m_sc < SAT) m_sc++;
            if (fl && m_fc < SAT) m_fc++;
            if (s.mop && !st) rem = LAT;
            else if (rem > 0) rem--;
        end
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [4:0] act;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {hz.PCWrite, hz.IF_ID_Write, hz.IF_ID_Flush, hz.ID_EX_Bubble, hz.mdu_busy};
            tests++;
            if (act !== e.ctl) begin
                fails++;
                $display("FAIL ctl {PCW,IFW,FL,BUB,BUSY} got %b want %b at %0t", act, e.ctl, $time);
            end
            if (e.chk_cnt) begin
                tests++;
                if (hz.stall_count !== e.sc) begin
                    fails++;
                    $display("FAIL stall_count got %0d want %0d at %0t", hz.stall_count, e.sc, $time);
                end
                tests++;
                if (hz.flush_count !== e.fc) begin
                    fails++;
                    $display("FAIL flush_count got %0d want %0d at %0t", hz.flush_count, e.fc, $time);
                end
            end
        end
    end

    initial begin
        stim_t s;
        s = nop(); s.rst_n = 0;
        repeat (2) step(s);
        // load-use
        s = nop(); s.exmr = 1; s.exrw = 1; s.exw = 8; s.rs = 8; s.urs = 1;
        step(s);
        step(nop());
        // load then dependent taken beq: EX match, MEM match, then flush
        s = nop(); s.exmr = 1; s.exrw = 1; s.exw = 8; s.rs = 8; s.urs = 1; s.br = 1; s.tk = 1;
        step(s);
        s = nop(); s.memr = 1; s.memw = 8; s.rs = 8; s.urs = 1; s.br = 1; s.tk = 1;
        step(s);
        s = nop(); s.rs = 8; s.urs = 1; s.br = 1; s.tk = 1;
        step(s);
        // $0 never matches
        s = nop(); s.exmr = 1; s.exrw = 1; s.exw = 0; s.rs = 0; s.urs = 1;
        step(s);
        // mult then back-to-back mfhi
        s = nop(); s.mop = 1;
        step(s);
        s = nop(); s.hilo = 1;
        repeat (4) step(s);
        step(nop());
        // jump while fetch not ready, then ready
        s = nop(); s.j = 1; s.ready = 0;
        repeat (5) step(s);
        s.ready = 1;
        step(s);
        // reset aborting BUSY
        s = nop(); s.mop = 1;
        step(s);
        step(nop());
        s = nop(); s.rst_n = 0;
        step(s);
        repeat (2) step(nop());
        // randomized traffic
        repeat (3000) step(rnd());
        // stall counter saturation
        s = nop(); s.ready = 0;
        repeat (SAT + 5) step(s);
        step(nop());
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
